// File: rtl/gclk_gate_ctrl.sv
// Enable sequencer for one gated global clock buffer shared by NREQ requesters.
// Only the buffer enable and the per-requester grants are driven; the clock path is untouched.
//
// state | meaning
// OFF   | buffer disabled, waiting for any request or FORCE
// WAKE  | buffer enabled, settling for WAKE_CYCLES before any grant
// ON    | buffer enabled, grants follow REQ, idle window counted
// DRAIN | buffer disabled, minimum off time before a re-wake
module gclk_gate_ctrl #(
    parameter int NREQ        = 4,
    parameter int WAKE_CYCLES = 4,
    parameter int IDLE_CYCLES = 16,
    parameter int MIN_OFF     = 2,
    parameter int CW          = 8
) (
    input  logic            CLK,
    input  logic            RST,
    input  logic [NREQ-1:0] REQ,
    input  logic            FORCE,
    output logic [NREQ-1:0] GNT,
    output logic            EN,
    output logic [1:0]      STATE
);

    typedef enum logic [1:0] {
        S_OFF   = 2'd0,
        S_WAKE  = 2'd1,
        S_ON    = 2'd2,
        S_DRAIN = 2'd3
    } state_t;

    localparam logic [CW-1:0] WAKE_LOAD = CW'(WAKE_CYCLES - 1);
    localparam logic [CW-1:0] IDLE_LAST = CW'(IDLE_CYCLES - 1);
    localparam logic [CW-1:0] OFF_LOAD  = CW'(MIN_OFF - 1);
    localparam logic [CW-1:0] CNT_ONE   = CW'(1);

    state_t          state_q, state_d;
    logic [CW-1:0]   wake_cnt_q, wake_cnt_d;
    logic [CW-1:0]   idle_cnt_q, idle_cnt_d;
    logic [CW-1:0]   off_cnt_q, off_cnt_d;
    logic [NREQ-1:0] gnt_q, gnt_d;
    logic            any_req;

    assign any_req = (|REQ) | FORCE;

    always_comb begin
        state_d    = state_q;
        wake_cnt_d = wake_cnt_q;
        idle_cnt_d = idle_cnt_q;
        off_cnt_d  = off_cnt_q;
        case (state_q)
            S_OFF: begin
                if (any_req) begin
                    state_d    = S_WAKE;
                    wake_cnt_d = WAKE_LOAD;
                end
            end
            S_WAKE: begin
                // Wake time runs to completion regardless of the requests.
                if (wake_cnt_q == '0) begin
                    state_d    = S_ON;
                    idle_cnt_d = '0;
                end else begin
                    wake_cnt_d = wake_cnt_q - CNT_ONE;
                end
            end
            S_ON: begin
                if (any_req) begin
                    idle_cnt_d = '0;
                end else if (idle_cnt_q == IDLE_LAST) begin
                    state_d   = S_DRAIN;
                    off_cnt_d = OFF_LOAD;
                end else begin
                    idle_cnt_d = idle_cnt_q + CNT_ONE;
                end
            end
            S_DRAIN: begin
                if (off_cnt_q == '0) begin
                    state_d = S_OFF;
                end else begin
                    off_cnt_d = off_cnt_q - CNT_ONE;
                end
            end
            default: state_d = S_OFF;
        endcase
    end

    // Grants only open after a full cycle of ON, so the first ON cycle shows zero.
    always_comb begin
        gnt_d = '0;
        if (state_q == S_ON) begin
            gnt_d = REQ;
        end
    end

    always_ff @(posedge CLK) begin
        if (RST) begin
            state_q    <= S_OFF;
            wake_cnt_q <= '0;
            idle_cnt_q <= '0;
            off_cnt_q  <= '0;
            gnt_q      <= '0;
        end else begin
            state_q    <= state_d;
            wake_cnt_q <= wake_cnt_d;
            idle_cnt_q <= idle_cnt_d;
            off_cnt_q  <= off_cnt_d;
            gnt_q      <= gnt_d;
        end
    end

    assign EN    = (state_q == S_WAKE) || (state_q == S_ON);
    assign STATE = state_q;
    assign GNT   = gnt_q;

endmodule
